mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the MIPS execute stage. It sits beside the single-cycle ALU and owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests through a start/busy/done handshake. It completes multiply and divide operations over multiple cycles, and the pipeline stalls on `busy`. HI and LO are always readable for MFHI/MFLO.

## Interface
- `MD_WIDTH`, 32: operand and HI/LO width. 64-bit product/remainder path internally.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request valid. Sampled only when `busy`=0.
- `op`  in  3: operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO (encodings from shared package).
- `opA`  in  32: rs value (multiplicand/dividend, or MTHI/MTLO source).
- `opB`  in  32: rt value (multiplier/divisor).
- `busy`  out  1: operation in flight. Pipeline must hold the instruction.
- `done`  out  1: one-cycle pulse. HI/LO updated this cycle.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset (async, `reset_n`=0): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, working regs cleared. Reset mid-operation aborts it; HI/LO read 0.
- IDLE with `start`=1:
  - MTHI/MTLO: write opA to HI/LO on that edge, `done`=1 next cycle, stay IDLE.
  - MULT/MULTU: go to MUL. DIV/DIVU: go to DIV.
  - Latch |opA| and |opB| (signed ops) or raw values (unsigned). Record result sign(s).
- `start` while `busy`=1: ignored, no queueing.
- MUL: shift-add radix-2, one multiplier bit per cycle, 32 cycles. Then FIX.
- DIV: restoring shift-subtract, one quotient bit per cycle, 32 cycles. Then FIX.
- FIX (1 cycle): apply signs, then write HI/LO.
  - Product: negate the 64-bit value if signs differ. HI = upper half, LO = lower half.
  - Quotient (LO): negated if signs differ.
  - Remainder (HI): takes the sign of the dividend.
  - Then IDLE with `done`=1.
- Divide by zero (opB=0, any DIV op): skip iteration and go to FIX directly. LO=0xFFFFFFFF, HI=opA unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the 32-bit wrap; no special case.
- Illegal `op` value: treated as no-op. No state change, no `done`.

## Timing
- Acceptance edge = E0.
- `busy` is high from after E0 until after the FIX edge.
- Normal MULT/DIV: 32 iteration edges (E1..E32), FIX at E33.
  - HI/LO are valid and `done`=1 in the cycle after E33.
  - `busy` falls in the same cycle. A back-to-back `start` is accepted at the next edge.
- Divide by zero: FIX at E1, `done` after E1.
- MTHI/MTLO: `busy` never asserted, `done` after E0.
- `hi`/`lo` are registered outputs. They hold their old values until the FIX edge, so MFHI during `busy` returns the stale value. The pipeline is required to stall it.

## Configuration
- `MULDIV_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle combinational 32x32 multiply.
  - Result is written at E1 (MUL state skipped; FIX at E1). `done` after E1.
  - Divide is unchanged.
- Not defined: iterative multiply, 33-edge latency as above.

## Structure
- Shared package holds:
  - the MD op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the state encoding;
  - the iteration count constant (32).
- One sub-module, `mult_div_step`: combinational single-iteration datapath.
  - Multiply mode: add/shift of the 64-bit accumulator.
  - Divide mode: trial subtract/shift of remainder:quotient.
  - Top level holds the FSM, counter, sign fix-up and HI/LO.

## Test plan
- MULT opA=0xFFFFFFFE, opB=3 -> after 33 edges `done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA. `busy` high exactly 33 cycles.
- MULTU opA=0xFFFFFFFE, opB=3 -> HI=0x00000002, LO=0xFFFFFFFA. Repeat with `MULDIV_FAST_MULT_EN`: same result, `done` after E1.
- DIV opA=-7 (0xFFFFFFF9), opB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU opA=100, opB=7 -> LO=0x0000000E, HI=0x00000002.
- DIV opA=0x80000000, opB=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU opA=0x1234, opB=0 -> `done` after E1, LO=0xFFFFFFFF, HI=0x00001234.
- MTHI 0xDEADBEEF then MTLO 0x0000BEEF on consecutive edges -> `busy` stays 0, `done` pulses twice, HI=0xDEADBEEF, LO=0x0000BEEF. A second `start` (MULT) asserted during `busy` is ignored: one `done`, result of the first op only.
- Start DIV, then drop `reset_n` at E10 -> `busy`=0, `hi`=`lo`=0 immediately. After release, MULT 6x7 -> LO=42, HI=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state encoding and the iteration count.
package mult_div_unit_pkg;

  localparam int unsigned MD_ITERS = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } md_state_e;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the multiply/divide datapath: radix-2 shift-add on the
// product accumulator, or restoring trial-subtract on remainder:quotient.
module mult_div_step #(
  parameter int unsigned W = 32
) (
  input  logic           div_mode,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] acc_next
);

  logic [W:0] sum;
  logic [W:0] trial;

  always_comb begin
    // Multiply: acc = {partial, multiplier}; the carry shifts into the top bit.
    sum   = {1'b0, acc[2*W-1:W]} + {1'b0, ({W{acc[0]}} & operand)};
    // Divide: the shifted remainder needs W+1 bits; bit W of trial is the borrow.
    trial = acc[2*W-1:W-1] - {1'b0, operand};
    if (div_mode) begin
      if (!trial[W]) acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
      else           acc_next = {acc[2*W-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MD_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [MD_WIDTH-1:0] opA,
  input  logic [MD_WIDTH-1:0] opB,
  output logic                busy,
  output logic                done,
  output logic [MD_WIDTH-1:0] hi,
  output logic [MD_WIDTH-1:0] lo
);

  localparam int unsigned W = MD_WIDTH;
  localparam logic [5:0] LAST = 6'(MD_ITERS - 1);

  md_state_e      state, state_nx;
  md_op_e         op_e;
  logic [5:0]     cnt;
  logic [2*W-1:0] acc, acc_next, fix_val;
  logic [W-1:0]   operand;
  logic           div_mode, neg_res, neg_rem, dz;

  logic           signed_op, a_neg, b_neg;
  logic [W-1:0]   a_abs, b_abs;

  assign op_e      = md_op_e'(op);
  assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign a_neg     = signed_op & opA[W-1];
  assign b_neg     = signed_op & opB[W-1];
  assign a_abs     = a_neg ? -opA : opA;
  assign b_abs     = b_neg ? -opB : opB;

  mult_div_step #(.W(W)) u_step (
    .div_mode (div_mode),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (start) begin
          case (op_e)
`ifdef MULDIV_FAST_MULT_EN
            MD_MULT, MD_MULTU: state_nx = ST_FIX;
`else
            MD_MULT, MD_MULTU: state_nx = ST_MUL;
`endif
            MD_DIV, MD_DIVU:   state_nx = (opB == '0) ? ST_FIX : ST_DIV;
            default:           state_nx = ST_IDLE;
          endcase
        end
      ST_MUL:  if (cnt == LAST) state_nx = ST_FIX;
      ST_DIV:  if (cnt == LAST) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Sign fix-up; divide-by-zero results are preloaded raw and bypass it.
  always_comb begin
    fix_val = acc;
    if (!dz) begin
      if (div_mode) begin
        fix_val[W-1:0]   = neg_res ? -acc[W-1:0]   : acc[W-1:0];
        fix_val[2*W-1:W] = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
      end else begin
        fix_val = neg_res ? -acc : acc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE:
          if (start) begin
            case (op_e)
              MD_MTHI: begin hi <= opA; done <= 1'b1; end
              MD_MTLO: begin lo <= opA; done <= 1'b1; end
              MD_MULT, MD_MULTU: begin
                div_mode <= 1'b0;
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= 1'b0;
                dz       <= 1'b0;
                cnt      <= '0;
                operand  <= a_abs;
`ifdef MULDIV_FAST_MULT_EN
                acc      <= {{W{1'b0}}, a_abs} * {{W{1'b0}}, b_abs};
`else
                acc      <= {{W{1'b0}}, b_abs};
`endif
              end
              MD_DIV, MD_DIVU: begin
                div_mode <= 1'b1;
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                cnt      <= '0;
                operand  <= b_abs;
                dz       <= (opB == '0);
                acc      <= (opB == '0) ? {opA, {W{1'b1}}} : {{W{1'b0}}, a_abs};
              end
              default: ;
            endcase
          end
        ST_MUL, ST_DIV: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
        end
        ST_FIX: begin
          hi   <= fix_val[2*W-1:W];
          lo   <= fix_val[W-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed/scoreboard bench for mult_div_unit with an independent arithmetic model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] opA = '0, opB = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mult_div_unit #(.MD_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .opA     (opA),
    .opB     (opB),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] mhi = '0, mlo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint xa, xb, q, r;
    logic [63:0] res;
    res = '0;
    case (o)
      MD_MULT:  begin xa = $signed(a); xb = $signed(b); res = 64'(xa * xb); end
      MD_MULTU: res = {32'b0, a} * {32'b0, b};
      MD_DIV:
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          xa = $signed(a); xb = $signed(b);
          q = xa / xb; r = xa % xb;
          res = {r[31:0], q[31:0]};
        end
      MD_DIVU:
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      MD_MTHI:  res = {a, mlo};
      MD_MTLO:  res = {mhi, a};
      default:  res = {mhi, mlo};
    endcase
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] m;
    int cyc, bsy;
    m = model(o, a, b);
    e.hi = m[63:32];
    e.lo = m[31:0];
    if (o == MD_MTHI || o == MD_MTLO)      e.lat = 0;
    else if (o == MD_MULT || o == MD_MULTU) e.lat = MUL_LAT;
    else                                    e.lat = (b == 0) ? 1 : 33;
    sb.push_back(e);
    mhi = e.hi;
    mlo = e.lo;
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; opA = $urandom; opB = $urandom;
    cyc = 0; bsy = 0;
    while (!done && cyc < 100) begin
      if (busy) bsy++;
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check({tag, ".latency"}, 32'(cyc), 32'(e.lat));
    check({tag, ".busycycles"}, 32'(bsy), 32'(e.lat));
    check({tag, ".busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, ".hi"}, hi, e.hi);
    check({tag, ".lo"}, lo, e.lo);
    @(negedge clk);
    check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int          ndone, nbusy;
    logic [31:0] rh, rl;

    #1;
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.done", {31'b0, done}, 32'd0);
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mult_neg",  MD_MULT,  32'hFFFFFFFE, 32'd3);
    run_op("multu",     MD_MULTU, 32'hFFFFFFFE, 32'd3);
    run_op("mult_min",  MD_MULT,  32'h80000000, 32'h80000000);
    run_op("div_neg",   MD_DIV,   32'hFFFFFFF9, 32'd2);
    run_op("divu",      MD_DIVU,  32'd100,      32'd7);
    run_op("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF);
    run_op("divu_zero", MD_DIVU,  32'h00001234, 32'd0);
    run_op("div_zero",  MD_DIV,   32'hFFFFFF00, 32'd0);
    run_op("div_negb",  MD_DIV,   32'd7,        32'hFFFFFFFE);

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; opA = 32'hDEADBEEF;
    @(negedge clk);
    check("mthi.done", {31'b0, done}, 32'd1);
    check("mthi.busy", {31'b0, busy}, 32'd0);
    check("mthi.hi", hi, 32'hDEADBEEF);
    op = MD_MTLO; opA = 32'h0000BEEF;
    @(negedge clk);
    start = 1'b0;
    check("mtlo.done", {31'b0, done}, 32'd1);
    check("mtlo.busy", {31'b0, busy}, 32'd0);
    check("mtlo.lo", lo, 32'h0000BEEF);
    check("mtlo.hi", hi, 32'hDEADBEEF);
    @(negedge clk);
    check("mtlo.done_pulse", {31'b0, done}, 32'd0);
    mhi = 32'hDEADBEEF; mlo = 32'h0000BEEF;

    // start while busy is ignored
    start = 1'b1; op = MD_DIVU; opA = 32'd100; opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 0; rh = '0; rl = '0;
    for (int i = 0; i < 60; i++) begin
      if (i == 5) begin start = 1'b1; op = MD_MULT; opA = 32'd6; opB = 32'd7; end
      else start = 1'b0;
      if (busy) nbusy++;
      if (done) begin ndone++; rh = hi; rl = lo; end
      @(negedge clk);
    end
    check("ignore.ndone", 32'(ndone), 32'd1);
    check("ignore.busycycles", 32'(nbusy), 32'd33);
    check("ignore.hi", rh, 32'd2);
    check("ignore.lo", rl, 32'd14);
    mhi = 32'd2; mlo = 32'd14;

    // illegal op code is a no-op
    start = 1'b1; op = 3'd6; opA = 32'h11111111; opB = 32'h22222222;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      @(negedge clk);
    end
    check("illegal.ndone", 32'(ndone), 32'd0);
    check("illegal.busy", 32'(nbusy), 32'd0);
    check("illegal.hi", hi, mhi);
    check("illegal.lo", lo, mlo);

    for (int k = 0; k < 8; k++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op($sformatf("rand%0d", k), ro, ra, rb);
    end

    // reset mid-divide aborts and clears HI/LO
    run_op("pre_reset", MD_DIV, 32'hFFFFFFF9, 32'd2);
    @(negedge clk);
    start = 1'b1; op = MD_DIV; opA = 32'd1000; opB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midop.busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.done", {31'b0, done}, 32'd0);
    check("abort.hi", hi, 32'd0);
    check("abort.lo", lo, 32'd0);
    mhi = '0; mlo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op("post_reset", MD_MULT, 32'd6, 32'd7);
    check("post_reset.lo42", lo, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
